// File: rtl/uart_rx_oversampled.sv
// Oversampling UART receiver: every clk is one sampling tick, frame = start, data LSB first,
// optional parity, stop. Define UART_RX_MAJORITY_VOTE_EN for 2-of-3 voting around mid-bit.
module uart_rx_oversampled #(
  parameter int unsigned parity_on           = 1,
  parameter int unsigned even_parity         = 1,
  parameter int unsigned data_size           = 8,
  parameter int unsigned no_of_clks          = 16,
  parameter int unsigned sampling_cntr_width = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Rx_s,
  output logic [data_size-1:0] Rx_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned CW   = sampling_cntr_width;
  localparam int unsigned BW   = (data_size > 1) ? $clog2(data_size) : 1;
  localparam int unsigned Half = no_of_clks / 2 - 1;
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int unsigned StartDecide = Half + 1;
`else
  localparam int unsigned StartDecide = Half;
`endif
  localparam logic [CW-1:0] CntStart = CW'(StartDecide);
  localparam logic [CW-1:0] CntLast  = CW'(no_of_clks - 1);
  localparam logic [BW-1:0] BitLast  = BW'(data_size - 1);
  localparam logic          ParOn    = (parity_on != 0);
  localparam logic          EvenBit  = (even_parity != 0);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e               r_state, w_state_nxt;
  logic [CW-1:0]        r_cnt, w_cnt_nxt;
  logic [BW-1:0]        r_bcnt, w_bcnt_nxt;
  logic [data_size-1:0] r_shift, w_shift_nxt;
  logic                 r_par, w_par_nxt;
  logic                 r_stop, w_stop_nxt;
  logic                 r_pend, w_pend_nxt;
  logic                 r_sync1, r_sync2, r_prev;
  logic                 w_bit;
  logic [data_size-1:0] r_rx_out;
  logic                 r_valid, r_perr, r_ferr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= Rx_s;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

`ifdef UART_RX_MAJORITY_VOTE_EN
  // Two-deep history of the synced line: with the live sample it spans ticks h-1, h, h+1.
  logic r_h0, r_h1;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_h0 <= 1'b1;
      r_h1 <= 1'b1;
    end else begin
      r_h0 <= r_sync2;
      r_h1 <= r_h0;
    end
  end
  assign w_bit = (r_h1 & r_h0) | (r_h1 & r_sync2) | (r_h0 & r_sync2);
`else
  assign w_bit = r_sync2;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_bcnt  <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_stop  <= 1'b1;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_shift <= w_shift_nxt;
      r_par   <= w_par_nxt;
      r_stop  <= w_stop_nxt;
      r_pend  <= w_pend_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bcnt_nxt  = r_bcnt;
    w_shift_nxt = r_shift;
    w_par_nxt   = r_par;
    w_stop_nxt  = r_stop;
    w_pend_nxt  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (r_prev && !r_sync2) begin
          w_state_nxt = StStart;
          w_cnt_nxt   = '0;
        end
      end
      StStart: begin
        if (r_cnt == CntStart) begin
          w_cnt_nxt = '0;
          if (!w_bit) begin
            w_state_nxt = StData;
            w_bcnt_nxt  = '0;
          end else begin
            w_state_nxt = StIdle;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      StData: begin
        if (r_cnt == CntLast) begin
          w_cnt_nxt           = '0;
          w_shift_nxt[r_bcnt] = w_bit;
          if (r_bcnt == BitLast) begin
            w_state_nxt = ParOn ? StParity : StStop;
          end else begin
            w_bcnt_nxt = r_bcnt + 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      StParity: begin
        if (r_cnt == CntLast) begin
          w_cnt_nxt   = '0;
          w_par_nxt   = w_bit;
          w_state_nxt = StStop;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      StStop: begin
        // Leave at mid-stop so a start edge half a bit later is still caught.
        if (r_cnt == CntLast) begin
          w_cnt_nxt   = '0;
          w_stop_nxt  = w_bit;
          w_pend_nxt  = 1'b1;
          w_state_nxt = StIdle;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = StIdle;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_out <= '0;
      r_valid  <= 1'b0;
      r_perr   <= 1'b0;
      r_ferr   <= 1'b0;
    end else begin
      r_valid <= r_pend;
      if (r_pend) begin
        r_rx_out <= r_shift;
        r_ferr   <= ~r_stop;
        r_perr   <= ParOn & (^r_shift ^ r_par ^ ~EvenBit);
      end
    end
  end

  assign Rx_out     = r_rx_out;
  assign data_valid = r_valid;
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;
  // The pending-output cycle still counts as busy so busy falls exactly as data_valid rises.
  assign busy       = (r_state != StIdle) | r_pend;

endmodule
